// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter built from per-bit JK flip-flop semantics.
// Ports: CLK, ClrN (async low), En, Up, Load, D -> Q, QN, TC, Wrap, LoadErr.
module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             ClrN,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TC,
  output logic             Wrap,
  output logic             LoadErr
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] j, k, tog, tgt;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             at_end, ld_bad, step;

  assign at_end = Up ? (q_q == MAXV) : (q_q == '0);
  assign TC     = En & ~Load & at_end;
  assign ld_bad = {1'b0, D} >= MODV;
  assign step   = En & ~Load & ~at_end;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    tog    = '0;
    tog[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++)
      tog[i] = tog[i-1] & (Up ? q_q[i-1] : ~q_q[i-1]);
  end

  // Value forced by a load or by the modulus override at the end.
  always_comb begin
    tgt = '0;
    if (Load)    tgt = ld_bad ? MAXV : D;
    else if (Up) tgt = '0;
    else         tgt = MAXV;
  end

  // Per-bit J/K drive; items are mutually exclusive by construction.
  always_comb begin
    j = '0;
    k = '0;
    unique case (1'b1)
      Load: begin
        j = tgt & ~q_q;
        k = ~tgt & q_q;
      end
      TC: begin
        j = q_q ^ tgt;
        k = q_q ^ tgt;
      end
      step: begin
        j = tog;
        k = tog;
      end
      default: ;
    endcase
  end

  assign q_d    = (j & ~q_q) | (~k & q_q);
  assign wrap_d = TC;
  assign err_d  = Load & ld_bad;

  always_ff @(posedge CLK or negedge ClrN) begin
    if (!ClrN) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Q       = q_q;
  assign QN      = ~q_q;
  assign Wrap    = wrap_q;
  assign LoadErr = err_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter: directed scenarios plus random steps,
// all checked against an arithmetic modulo-N reference model.
module tb_jk_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         CLK = 1'b0;
  logic         ClrN = 1'b0;
  logic         En = 1'b0;
  logic         Up = 1'b1;
  logic         Load = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q, QN;
  logic         TC, Wrap, LoadErr;

  int n_chk = 0;
  int n_fail = 0;

  int mq = 0;
  int mwrap = 0;
  int merr = 0;

  jk_updown_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .CLK(CLK), .ClrN(ClrN), .En(En), .Up(Up),
    .Load(Load), .D(D), .Q(Q), .QN(QN),
    .TC(TC), .Wrap(Wrap), .LoadErr(LoadErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_tc();
    if (!En || Load) return 0;
    return Up ? int'(mq == MOD - 1) : int'(mq == 0);
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, ".Q"}, int'(Q), mq);
    chk({tag, ".QN"}, int'(QN), (~mq) & ((1 << W) - 1));
    chk({tag, ".Wrap"}, int'(Wrap), mwrap);
    chk({tag, ".LoadErr"}, int'(LoadErr), merr);
  endtask

  // Drive inputs mid-low-phase, check TC, clock once, check outputs.
  task automatic step(input string tag, input logic en, input logic up,
                      input logic ld, input int d);
    int tc;
    En = en; Up = up; Load = ld; D = W'(d);
    #1;
    tc = m_tc();
    chk({tag, ".TC"}, int'(TC), tc);
    @(posedge CLK);
    mwrap = tc;
    merr  = int'(ld && d >= MOD);
    if (ld)       mq = (d < MOD) ? d : MOD - 1;
    else if (en)  mq = up ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
    #1;
    chk_out(tag);
    @(negedge CLK);
  endtask

  // Async clear between edges, with junk inputs that must be ignored.
  task automatic pulse_reset(input string tag);
    #2;
    En = 1'b1; Load = 1'b1; D = W'(12); Up = $urandom_range(0, 1);
    ClrN = 1'b0;
    #1;
    mq = 0; mwrap = 0; merr = 0;
    chk_out({tag, ".async"});
    @(posedge CLK);
    #1;
    chk_out({tag, ".held"});
    @(negedge CLK);
    ClrN = 1'b1;
  endtask

  initial begin
    // reset state
    #3;
    mq = 0; mwrap = 0; merr = 0;
    chk_out("reset");
    @(negedge CLK);
    ClrN = 1'b1;
    // up count 1..9,0,1,2
    for (int i = 0; i < 12; i++) step("up", 1, 1, 0, 0);
    // down from 0 -> 9 -> 8
    step("ld0", 0, 1, 1, 0);
    step("dn", 1, 0, 0, 0);
    step("dn", 1, 0, 0, 0);
    // loads
    step("ld7", 0, 1, 1, 7);
    step("ld12", 0, 1, 1, 12);
    step("ld12.after", 0, 1, 0, 0);
    step("ld15", 1, 1, 1, 15);
    step("ldEn9", 1, 1, 1, 9);
    step("ldEn9.after", 0, 1, 0, 0);
    // hold for 3 edges
    for (int i = 0; i < 3; i++) step("hold", 0, 1, 0, 0);
    // reverse at 5
    step("ld5", 0, 1, 1, 5);
    step("rev", 1, 0, 0, 0);
    step("rev2", 1, 1, 0, 0);
    // reset mid-run at 6
    step("ld6", 0, 1, 1, 6);
    pulse_reset("rst6");
    step("resume", 1, 1, 0, 0);
    // reset during a bad load
    step("ld2", 0, 1, 1, 2);
    pulse_reset("rstld");
    step("resume2", 1, 0, 0, 0);
    // random
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd.rst");
      else step("rnd", 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MODULUS, default 10: count range 0..MODULUS-1; legal values 2..2^WIDTH.
REQ-003 CLK  input  1: single clock; all state updates on its rising edge.
REQ-004 ClrN  input  1: asynchronous, active-low reset.
REQ-005 En  input  1: count enable.
REQ-006 Up  input  1: direction; 1 = increment, 0 = decrement.
REQ-007 Load  input  1: synchronous parallel load request.
REQ-008 D  input  WIDTH: parallel load value.
REQ-009 Q  output  WIDTH: registered count.
REQ-010 QN  output  WIDTH: bitwise complement of Q.
REQ-011 TC  output  1: terminal count, combinational.
REQ-012 Wrap  output  1: registered one-cycle pulse.
REQ-013 LoadErr  output  1: registered one-cycle pulse.

Function
REQ-014 Each Q bit SHALL update with JK semantics: J=K=1 toggles the bit, J=K=0 holds it; for a plain binary step, bit i toggles when all lower bits are 1 (up) or all 0 (down).
REQ-015 Priority each edge SHALL be Load > En > hold.
REQ-016 Load=1 with D < MODULUS: Q <= D next edge; Wrap <= 0; LoadErr <= 0.
REQ-017 Load=1 with D >= MODULUS: Q <= MODULUS-1; LoadErr <= 1 for exactly one cycle.
REQ-018 Load=0, En=1, Up=1: Q <= Q+1; at Q = MODULUS-1, Q <= 0 instead of the binary step (modulus override).
REQ-019 Load=0, En=1, Up=0: Q <= Q-1; at Q = 0, Q <= MODULUS-1.
REQ-020 Load=0, En=0: Q holds; Wrap <= 0; LoadErr <= 0.
REQ-021 TC SHALL = En & ~Load & (Up ? Q==MODULUS-1 : Q==0).
REQ-022 Wrap SHALL be 1 in the cycle after any edge that sampled TC=1; otherwise 0.
REQ-023 Latency: one CLK edge from a sampled input to Q, Wrap or LoadErr; TC has zero latency.
REQ-024 Direction change SHALL take effect on the same edge it is sampled; no dead cycle.
REQ-025 Simultaneous Load and En: Load wins; no count step and no Wrap.
REQ-026 QN SHALL equal ~Q in every cycle, including during reset.
REQ-027 With MODULUS = 2^WIDTH, wrap SHALL occur by natural binary overflow and underflow, and LoadErr SHALL never assert.

Reset
REQ-028 ClrN=0 SHALL force Q=0, QN=all-ones, Wrap=0 and LoadErr=0 immediately, independent of CLK.
REQ-029 While ClrN=0, the block SHALL ignore Load, En, Up and D.
REQ-030 After ClrN deasserts, the block SHALL resume counting on the first rising CLK edge; no extra sync cycle is required.
REQ-031 ClrN asserted mid-count or mid-load SHALL abort that operation; no Wrap or LoadErr pulse is produced for it.

Verification
REQ-032 Reset: ClrN=0 between clock edges -> Q=0, QN=4'hF, Wrap=0 and LoadErr=0 before the next edge.
REQ-033 Up-count: WIDTH=4, MODULUS=10, En=1, Up=1, 12 edges from 0 -> Q sequence 1..9,0,1,2; TC=1 while Q=9; Wrap=1 only in the cycle after the 9->0 edge.
REQ-034 Down-count: start Q=0, Up=0, En=1 -> Q=9 then 8; TC=1 at Q=0; one Wrap pulse.
REQ-035 Load: D=7 -> Q=7, LoadErr=0; D=12 -> Q=9, LoadErr=1 for one cycle; Load=1 with En=1 at Q=9 -> no Wrap.
REQ-036 Hold and reversal: En=0 for 3 edges -> Q unchanged; Up toggled 1->0 at Q=5 -> next Q=4.
REQ-037 Async reset mid-run: ClrN pulsed low at Q=6 -> Q=0 at once; counting resumes 0->1 on the first edge after release.
